// File: rtl/board_io_ctrl_pkg.sv
// Shared definitions for the board I/O controller: segment encoding,
// blank-display constant and the counter-width helper.
package board_io_pkg;

    typedef logic [6:0] seg_t;  // {g,f,e,d,c,b,a}, active low

    localparam seg_t SEG_BLANK = 7'h7F;

    // Bits needed to hold a counter value 0..max_count (never less than 1).
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    // Hex digit to active-low 7-segment pattern.
    function automatic seg_t hex_to_seg(input logic [3:0] digit);
        seg_t seg;
        case (digit)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/board_io_ctrl_if.sv
// Board-side and fabric-side signal bundle of the I/O controller.
// master = the environment (pins, fabric, display source); slave = the controller.
interface board_io_ctrl_if #(
    parameter int NUM_IOS       = 8,
    parameter int NUM_OF_ANODES = 4
);
    logic [NUM_IOS-1:0]         pad_i;
    logic [NUM_IOS-1:0]         pad_o;
    logic [NUM_IOS-1:0]         pad_oe;
    logic [NUM_IOS-1:0]         I_top;
    logic [NUM_IOS-1:0]         T_top;
    logic [NUM_IOS-1:0]         O_top;
    logic [NUM_IOS-1:0]         edge_o;
    logic [NUM_IOS-1:0]         debounce_en;
    logic [4*NUM_OF_ANODES-1:0] display_value;
    logic [NUM_OF_ANODES-1:0]   dp_mask;
    logic                       display_en;
    logic [NUM_OF_ANODES-1:0]   an;
    logic [6:0]                 seg;
    logic                       dp;
    logic                       heartbeat;

    modport master (
        output pad_i, I_top, T_top, debounce_en, display_value, dp_mask, display_en,
        input  pad_o, pad_oe, O_top, edge_o, an, seg, dp, heartbeat
    );

    modport slave (
        input  pad_i, I_top, T_top, debounce_en, display_value, dp_mask, display_en,
        output pad_o, pad_oe, O_top, edge_o, an, seg, dp, heartbeat
    );
endinterface

// File: rtl/board_io_ctrl_io_debounce.sv
// One input channel: 2-FF synchroniser, debounce counter with bypass,
// stable (accepted) value and a one-cycle change pulse.
module io_debounce
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 12000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pad,
    input  logic i_debounce_en,
    output logic o_stable,
    output logic o_edge
);
    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic          r_edge;
    logic [CW-1:0] r_cnt;

    logic          w_stable_next;
    logic [CW-1:0] w_cnt_next;

    // Accept the synchronised value once it has disagreed for DEBOUNCE_CYCLES samples.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_stable_next = r_stable;
        w_cnt_next    = '0;
        if (!i_debounce_en) begin
            w_stable_next = r_sync2;
        end else if (r_sync2 != r_stable) begin
            if (r_cnt == CNT_LAST) begin
                w_stable_next = r_sync2;
            end else begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end
    end

    // Synchroniser, counter, stable value and change pulse.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
            r_edge   <= 1'b0;
        end else begin
            r_sync1  <= i_pad;
            r_sync2  <= r_sync1;
            r_stable <= w_stable_next;
            r_cnt    <= w_cnt_next;
            r_edge   <= w_stable_next ^ r_stable;
        end
    end

    assign o_stable = r_stable;
    assign o_edge   = r_edge;

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O controller: registered tristate drive, conditioned inputs with
// change pulses, multiplexed 7-segment display and a heartbeat.
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int NUM_IOS         = 8,
    parameter int NUM_OF_ANODES   = 4,
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int SCAN_CYCLES     = 12000,
    parameter int HEARTBEAT_BIT   = 23
) (
    input logic            clk,
    input logic            reset,
    board_io_ctrl_if.slave bus
);
    localparam int NA = NUM_OF_ANODES;
    localparam int PW = cnt_width(SCAN_CYCLES - 1);
    localparam int IW = cnt_width(NA - 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NA - 1);
    localparam logic [NA-1:0] AN_ONE     = NA'(1);

    logic [NUM_IOS-1:0]   r_pad_o;
    logic [NUM_IOS-1:0]   r_pad_oe;
    logic [NUM_IOS-1:0]   w_stable;
    logic [NUM_IOS-1:0]   w_edge;

    logic [PW-1:0]        r_presc;
    logic [IW-1:0]        r_idx;
    logic [4*NA-1:0]      r_frame_val;
    logic [NA-1:0]        r_frame_dp;
    logic [NA-1:0]        r_an;
    seg_t                 r_seg;
    logic                 r_dp;
    logic [HEARTBEAT_BIT:0] r_hb;

    logic [PW-1:0]        w_presc_next;
    logic [IW-1:0]        w_idx_next;
    logic [4*NA-1:0]      w_frame_val_next;
    logic [NA-1:0]        w_frame_dp_next;
    logic [3:0]           w_digit;
    logic [NA-1:0]        w_dp_shift;

    // Pin drive follows the fabric one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pad_o  <= '0;
            r_pad_oe <= '0;
        end else begin
            r_pad_o  <= bus.I_top;
            r_pad_oe <= bus.T_top;
        end
    end

    for (genvar g = 0; g < NUM_IOS; g++) begin : g_io
        io_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_io_debounce (
            .clk          (clk),
            .reset        (reset),
            .i_pad        (bus.pad_i[g]),
            .i_debounce_en(bus.debounce_en[g]),
            .o_stable     (w_stable[g]),
            .o_edge       (w_edge[g])
        );
    end

    // Scan position and frame contents that take effect at the coming edge.
    always_comb begin
        w_presc_next     = r_presc + 1'b1;
        w_idx_next       = r_idx;
        w_frame_val_next = r_frame_val;
        w_frame_dp_next  = r_frame_dp;
        if (r_presc == PRESC_LAST) begin
            w_presc_next = '0;
            if (r_idx == IDX_LAST) begin
                w_idx_next       = '0;
                w_frame_val_next = bus.display_value;
                w_frame_dp_next  = bus.dp_mask;
            end else begin
                w_idx_next = r_idx + 1'b1;
            end
        end
        w_digit    = 4'(w_frame_val_next >> {w_idx_next, 2'b00});
        w_dp_shift = w_frame_dp_next >> w_idx_next;
    end

    // Digit scanning, frame latch and registered display drive.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the frame register is small and reset so the first frame shows zeros, not X.
            r_presc     <= '0;
            r_idx       <= '0;
            r_frame_val <= '0;
            r_frame_dp  <= '0;
            r_an        <= '1;
            r_seg       <= SEG_BLANK;
            r_dp        <= 1'b1;
        end else begin
            r_presc     <= w_presc_next;
            r_idx       <= w_idx_next;
            r_frame_val <= w_frame_val_next;
            r_frame_dp  <= w_frame_dp_next;
            if (bus.display_en) begin
                r_an  <= ~(AN_ONE << w_idx_next);
                r_seg <= hex_to_seg(w_digit);
                r_dp  <= ~w_dp_shift[0];
            end else begin
                r_an  <= '1;
                r_seg <= SEG_BLANK;
                r_dp  <= 1'b1;
            end
        end
    end

    // Free-running heartbeat counter; its MSB is a 50% duty square wave.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hb <= '0;
        end else begin
            r_hb <= r_hb + 1'b1;
        end
    end

    assign bus.pad_o     = r_pad_o;
    assign bus.pad_oe    = r_pad_oe;
    assign bus.O_top     = w_stable;
    assign bus.edge_o    = w_edge;
    assign bus.an        = r_an;
    assign bus.seg       = r_seg;
    assign bus.dp        = r_dp;
    assign bus.heartbeat = r_hb[HEARTBEAT_BIT];

endmodule

// File: tb/tb_board_io_ctrl.sv
// Scoreboard bench for board_io_ctrl: the driver applies one stimulus per
// clock and queues the reference model's expected outputs; the monitor pops
// and compares after every rising edge.
module tb_board_io_ctrl;

    localparam int NIO  = 4;
    localparam int NAN  = 4;
    localparam int DEB  = 4;
    localparam int SCAN = 3;
    localparam int HBB  = 3;

    typedef struct packed {
        logic        rst;
        logic [3:0]  pad;
        logic [3:0]  itop;
        logic [3:0]  ttop;
        logic [3:0]  deb;
        logic [15:0] dval;
        logic [3:0]  dpm;
        logic        den;
    } stim_t;

    typedef struct packed {
        logic [3:0] pad_o;
        logic [3:0] pad_oe;
        logic [3:0] o_top;
        logic [3:0] edge_o;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       hb;
    } exp_t;

    logic clk;
    logic reset;

    board_io_ctrl_if #(.NUM_IOS(NIO), .NUM_OF_ANODES(NAN)) bus ();

    board_io_ctrl #(
        .NUM_IOS        (NIO),
        .NUM_OF_ANODES  (NAN),
        .DEBOUNCE_CYCLES(DEB),
        .SCAN_CYCLES    (SCAN),
        .HEARTBEAT_BIT  (HBB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent active-low hex font, {g,f,e,d,c,b,a}.
    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    exp_t  exp_q [$];
    stim_t cur;
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    bit    drv_done = 0;
    bit    mon_done = 0;

    // Reference model state
    logic [3:0]  m_pipe [$];   // pad samples still travelling through the synchroniser
    int          m_run [NIO];  // consecutive debounced samples disagreeing with the accepted value
    logic [3:0]  m_stable;
    int          m_n;          // rising edges since reset was released
    logic [15:0] m_fval;
    logic [3:0]  m_fdp;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, req);
        end
    endtask

    task automatic predict(input stim_t s, output exp_t e);
        logic [3:0] seen;
        logic [3:0] nxt;
        logic [3:0] nib;
        int         idx;
        if (s.rst) begin
            m_pipe.delete();
            m_pipe.push_back(4'h0);
            m_pipe.push_back(4'h0);
            for (int i = 0; i < NIO; i++) m_run[i] = 0;
            m_stable = '0;
            m_n      = 0;
            m_fval   = '0;
            m_fdp    = '0;
            e.pad_o  = '0;
            e.pad_oe = '0;
            e.o_top  = '0;
            e.edge_o = '0;
            e.an     = 4'hF;
            e.seg    = 7'h7F;
            e.dp     = 1'b1;
            e.hb     = 1'b0;
        end else begin
            seen = m_pipe.pop_front();
            m_pipe.push_back(s.pad);
            nxt = m_stable;
            for (int i = 0; i < NIO; i++) begin
                if (!s.deb[i]) begin
                    nxt[i]   = seen[i];
                    m_run[i] = 0;
                end else if (seen[i] == m_stable[i]) begin
                    m_run[i] = 0;
                end else begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        nxt[i]   = seen[i];
                        m_run[i] = 0;
                    end
                end
            end
            e.edge_o = nxt ^ m_stable;
            e.o_top  = nxt;
            m_stable = nxt;
            e.pad_o  = s.itop;
            e.pad_oe = s.ttop;

            m_n++;
            if (m_n % (SCAN * NAN) == 0) begin
                m_fval = s.dval;
                m_fdp  = s.dpm;
            end
            idx = (m_n / SCAN) % NAN;
            nib = 4'(m_fval >> (4 * idx));
            if (s.den) begin
                e.an  = ~(4'b0001 << idx);
                e.seg = hex_tab[nib];
                e.dp  = ~m_fdp[idx];
            end else begin
                e.an  = 4'hF;
                e.seg = 7'h7F;
                e.dp  = 1'b1;
            end
            e.hb = (m_n % (1 << (HBB + 1))) >= (1 << HBB);
        end
    endtask

    task automatic step();
        exp_t e;
        reset             = cur.rst;
        bus.pad_i         = cur.pad;
        bus.I_top         = cur.itop;
        bus.T_top         = cur.ttop;
        bus.debounce_en   = cur.deb;
        bus.display_value = cur.dval;
        bus.dp_mask       = cur.dpm;
        bus.display_en    = cur.den;
        predict(cur, e);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Driver: directed scenarios followed by a randomized run.
    initial begin : driver
        cur = '0;
        cur.rst = 1'b1;
        repeat (5) begin
            cur.pad  = 4'($urandom);
            cur.itop = 4'($urandom);
            cur.ttop = 4'($urandom);
            cur.deb  = 4'($urandom);
            cur.dval = 16'($urandom);
            cur.dpm  = 4'($urandom);
            cur.den  = 1'b1;
            step();
        end
        cur     = '0;
        cur.deb = 4'hF;
        repeat (4) step();

        cur.pad[0] = 1'b1;
        repeat (10) step();

        cur.pad[1] = 1'b1;
        repeat (3) step();
        cur.pad[1] = 1'b0;
        repeat (10) step();

        cur.deb[1] = 1'b0;
        repeat (2) step();
        cur.pad[1] = 1'b1;
        repeat (3) step();
        cur.pad[1] = 1'b0;
        repeat (6) step();

        cur.itop = 4'hA;
        cur.ttop = 4'hC;
        repeat (2) step();

        cur.dval = 16'h81F0;
        cur.dpm  = 4'b0010;
        cur.den  = 1'b1;
        repeat (31) step();
        cur.dval = 16'h3C5E;
        repeat (20) step();
        cur.den = 1'b0;
        repeat (4) step();
        cur.den = 1'b1;
        repeat (5) step();

        repeat (32) step();

        repeat (4) step();
        cur.rst = 1'b1;
        step();
        cur.rst = 1'b0;
        repeat (14) step();

        repeat (700) begin
            for (int i = 0; i < NIO; i++)
                if ($urandom_range(0, 5) == 0) cur.pad[i] = ~cur.pad[i];
            if ($urandom_range(0, 49) == 0) cur.deb = 4'($urandom);
            cur.itop = 4'($urandom);
            cur.ttop = 4'($urandom);
            if ($urandom_range(0, 9) == 0) cur.dval = 16'($urandom);
            if ($urandom_range(0, 9) == 0) cur.dpm = 4'($urandom);
            if ($urandom_range(0, 29) == 0) cur.den = ~cur.den;
            cur.rst = ($urandom_range(0, 199) == 0);
            step();
        end
        drv_done = 1'b1;
    end

    // Monitor: compare every DUT output against the queued expectation.
    initial begin : monitor
        exp_t e;
        bit   stop;
        stop = 0;
        while (!stop) begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() == 0) begin
                if (drv_done) begin
                    stop = 1;
                end else begin
                    total++;
                    bad++;
                    $display("FAIL exp_queue cycle=%0d actual=empty required=entry", cyc);
                end
            end else begin
                e = exp_q.pop_front();
                check("pad_o",     32'(bus.pad_o),     32'(e.pad_o));
                check("pad_oe",    32'(bus.pad_oe),    32'(e.pad_oe));
                check("O_top",     32'(bus.O_top),     32'(e.o_top));
                check("edge_o",    32'(bus.edge_o),    32'(e.edge_o));
                check("an",        32'(bus.an),        32'(e.an));
                check("seg",       32'(bus.seg),       32'(e.seg));
                check("dp",        32'(bus.dp),        32'(e.dp));
                check("heartbeat", 32'(bus.heartbeat), 32'(e.hb));
            end
        end
        mon_done = 1'b1;
    end

    // End of run: wait (bounded) for the monitor to drain, then summarise.
    initial begin : finisher
        wait (drv_done);
        repeat (10) if (!mon_done) @(posedge clk);
        if (!mon_done) begin
            total++;
            bad++;
            $display("FAIL monitor_drain actual=running required=done");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/board_io_ctrl.md
# board_io_ctrl

Parametrised board I/O controller for the FPGA top level, placed between the physical pins and the fabric's I_top/O_top/T_top user-IO vectors. It replaces fixed pin wiring with registered tristate drive, per-channel synchroniser/debouncer with a selectable bypass, and change-pulse reporting. It also drives a multiplexed 7-segment display instead of blanking it, and generates a heartbeat.

## Interface
Parameters:
- NUM_IOS, 8, number of user IO channels (≥1)
- NUM_OF_ANODES, 4, 7-segment digits (≥1)
- DEBOUNCE_CYCLES, 12000, stable-input cycles required before accepting a change (≥1; 1 ms at 12 MHz)
- SCAN_CYCLES, 12000, cycles each digit is lit (≥1)
- HEARTBEAT_BIT, 23, heartbeat counter bit routed to output

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pad_i  in  NUM_IOS  pin input value
- pad_o  out  NUM_IOS  pin output value
- pad_oe  out  NUM_IOS  pin output enable (1 = drive)
- I_top  in  NUM_IOS  fabric data to drive
- T_top  in  NUM_IOS  fabric drive enable (1 = drive)
- O_top  out  NUM_IOS  conditioned input to fabric
- edge_o  out  NUM_IOS  one-cycle pulse on each O_top change
- debounce_en  in  NUM_IOS  per channel: 1 = debounce, 0 = synchronise only
- display_value  in  4*NUM_OF_ANODES  hex digits; nibble d drives digit d
- dp_mask  in  NUM_OF_ANODES  1 = light decimal point of digit d
- display_en  in  1  0 = blank display
- an  out  NUM_OF_ANODES  anodes, active low
- seg  out  7  segments {g,f,e,d,c,b,a}, active low
- dp  out  1  decimal point, active low
- heartbeat  out  1  counter bit HEARTBEAT_BIT

## Operation
- Reset values: pad_o=0, pad_oe=0, O_top=0, edge_o=0, an=all 1, seg=7'h7F, dp=1, heartbeat=0, digit index 0, all counters 0, sync stages 0.
- Output path: pad_o<=I_top, pad_oe<=T_top, registered.
- Input path, per channel: 2-FF synchroniser (sync2), stable register, counter of width $clog2(DEBOUNCE_CYCLES+1).
  - debounce_en=1: if sync2==stable, cnt<=0; else if cnt==DEBOUNCE_CYCLES-1, stable<=sync2 and cnt<=0; else cnt++.
  - debounce_en=0: stable<=sync2 and cnt<=0 every cycle.
  - Any mismatch resolved within the window (input returns) clears cnt; glitches shorter than DEBOUNCE_CYCLES are never passed through.
  - O_top=stable. edge_o asserts the cycle after stable changes, for exactly one cycle.
  - The input is conditioned even while the channel drives (loopback).
- Display: a prescaler counts 0..SCAN_CYCLES-1. On wrap, the digit index advances 0..NUM_OF_ANODES-1 and wraps to 0.
  - display_value and dp_mask are latched into a frame register when the index wraps to 0, so a frame never mixes two values.
  - When display_en=1: an = ~(1<<index); seg = hex decode of the frame nibble; dp = ~dp_mask[index].
  - When display_en=0: an all 1, seg 7'h7F, dp 1. Scanning continues, so re-enable is immediate.
- Heartbeat: free-running counter of width HEARTBEAT_BIT+1 that wraps; heartbeat is its MSB.
- Reset mid-operation: all of the above return to their reset values on the next edge, including any debounce in progress.

## Timing
- Output path: pad_o/pad_oe follow I_top/T_top with 1 cycle latency.
- Debounced input: a new pad_i value first sampled at edge k (and held) appears on O_top after edge k+1+DEBOUNCE_CYCLES. The edge_o pulse is coincident with that update.
- Bypassed input: the same value appears on O_top after edge k+2.
- Display: each digit is lit for exactly SCAN_CYCLES cycles; a full frame is NUM_OF_ANODES*SCAN_CYCLES cycles. seg/an/dp are registered and update on the edge at which the index changes.
- Heartbeat period: 2^(HEARTBEAT_BIT+1) cycles, with a 50% duty cycle.
- debounce_en change mid-count: the new mode applies from the next edge; the counter is cleared in bypass.

## Structure
- Package board_io_pkg holds:
  - the hex-to-segment function, active low: 0→7'b1000000, 1→7'b1111001, 8→7'b0000000, F→7'b0001110;
  - the blank-segment constant 7'h7F;
  - a counter-width helper.
- Sub-module io_debounce: one channel (synchroniser, counter, stable register, edge pulse), instantiated NUM_IOS times in a generate loop.
- The scan, frame latch and heartbeat logic live in the top module.

## Test plan
Parameters for the bench: NUM_IOS=4, NUM_OF_ANODES=4, DEBOUNCE_CYCLES=4, SCAN_CYCLES=3, HEARTBEAT_BIT=3.
- Reset with inputs toggling -> all outputs at their reset values; O_top=0; no edge_o pulses while reset is high.
- pad_i[0] 0→1 held, debounce_en=1 -> O_top[0]=1 after edge k+5; edge_o[0] high for exactly that one cycle.
- pad_i[1] 3-cycle high glitch, debounce_en=1 -> O_top[1] stays 0 and edge_o[1] never fires. Same glitch with debounce_en=0 -> O_top[1] high for 3 cycles with two edge_o pulses.
- I_top=4'hA, T_top=4'hC -> next cycle pad_o=4'hA, pad_oe=4'hC.
- display_value=16'h81F0, dp_mask=4'b0010, display_en=1 -> an cycles 1110,1101,1011,0111, each for 3 cycles; seg=1000000, 0001110 (dp=0), 1111001, 0000000. A display_value change mid-frame appears only from the next frame. display_en=0 blanks the display on the next edge.
- Free run of 32 cycles -> heartbeat toggles every 8 cycles. Assert reset mid-frame -> an=all 1 and digit index 0 on the next edge.
